sic_fetch_feeder: RTL and testbench

// - Fetch-side instruction source for RIDECORE single-instruction checking (SIC).
// - Registers the free, formally constrained 32-bit instruction word and presents it to the core fetch port over a valid/ready handshake.
// - Converts the stall encoding (opcode 7'b1111111) into valid=0.
// - Sequences each run through four phases: warm-up, issue of N instructions under test, drain, done.

---
 rtl/sic_pkg.sv | 26 ++
 rtl/sic_down_counter.sv | 29 ++
 rtl/sic_fetch_feeder.sv | 117 +++++++++++
 tb/tb_sic_fetch_feeder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sic_pkg.sv
// Shared opcode constants and phase encoding for the SIC fetch feeder.
package sic_pkg;

    localparam logic [6:0] OPC_STALL  = 7'h7F;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        WARM  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sic_phase_t;

    function automatic logic is_stall(input logic [31:0] word);
        return word[6:0] == OPC_STALL;
    endfunction

endpackage

// File: rtl/sic_down_counter.sv
// Loadable down counter shared by the WARM and DRAIN phases of the fetch feeder.
module sic_down_counter #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             reset_x,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;

    // Flags the cycle in which the count expires, so a phase of N cycles lasts exactly N.
    assign zero = (count_q == '0) | (dec & (count_q == CNT_W'(1)));

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            count_q <= CNT_W'(RST_VAL);
        end else if (load) begin
            count_q <= value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/sic_fetch_feeder.sv
// SIC fetch-side instruction source: warm-up, issue, drain, done sequencing over valid/ready.
// Optional capture of the first transferred instruction under `SIC_FEEDER_CAPTURE_EN.
module sic_fetch_feeder
    import sic_pkg::*;
#(
    parameter int unsigned WARM_CYCLES  = 4,
    parameter int unsigned MAX_ISSUE    = 1,
    parameter int unsigned DRAIN_CYCLES = 16,
    parameter int unsigned CNT_W        = 8
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic [31:0] instruction,
    input  logic        fetch_ready,
    output logic [31:0] inst_out,
    output logic        inst_valid,
    output logic [7:0]  issue_count,
    output logic [1:0]  phase,
    output logic        run_done
`ifdef SIC_FEEDER_CAPTURE_EN
    ,
    output logic [31:0] cap_inst,
    output logic [15:0] cap_cycle
`endif
);

    localparam logic [8:0] MAX_I = 9'(MAX_ISSUE);

    sic_phase_t phase_q;
    logic       in_issue;
    logic       transfer;
    logic [8:0] count_next;
    logic       load_en;
    logic       last_xfer;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_zero;

    assign phase      = phase_q;
    assign in_issue   = (phase_q == ISSUE);
    assign transfer   = in_issue & inst_valid & fetch_ready;
    assign count_next = {1'b0, issue_count} + {8'd0, transfer};
    assign load_en    = in_issue & (~inst_valid | transfer) & (count_next < MAX_I);
    assign last_xfer  = transfer & (count_next == MAX_I);
    assign cnt_load   = last_xfer & (DRAIN_CYCLES != 0);
    assign cnt_dec    = (phase_q == WARM) | (phase_q == DRAIN);

    sic_down_counter #(
        .CNT_W   (CNT_W),
        .RST_VAL (WARM_CYCLES)
    ) u_cnt (
        .clk     (clk),
        .reset_x (reset_x),
        .load    (cnt_load),
        .value   (CNT_W'(DRAIN_CYCLES)),
        .dec     (cnt_dec),
        .zero    (cnt_zero)
    );

    // Output register stage: instruction sampled in cycle t is presented in t+1.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            phase_q     <= WARM;
            inst_out    <= '0;
            inst_valid  <= 1'b0;
            issue_count <= '0;
            run_done    <= 1'b0;
        end else begin
            case (phase_q)
                WARM: begin
                    if (cnt_zero) phase_q <= ISSUE;
                end
                ISSUE: begin
                    if (transfer) issue_count <= issue_count + 8'd1;
                    if (last_xfer) begin
                        inst_valid <= 1'b0;
                        if (DRAIN_CYCLES == 0) begin
                            phase_q  <= DONE;
                            run_done <= 1'b1;
                        end else begin
                            phase_q <= DRAIN;
                        end
                    end else if (load_en) begin
                        inst_out   <= instruction;
                        inst_valid <= ~is_stall(instruction);
                    end
                end
                DRAIN: begin
                    if (cnt_zero) begin
                        phase_q  <= DONE;
                        run_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SIC_FEEDER_CAPTURE_EN
    logic [15:0] cycle_q;

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            cycle_q   <= '0;
            cap_inst  <= '0;
            cap_cycle <= '0;
        end else begin
            if (cycle_q != 16'hFFFF) cycle_q <= cycle_q + 16'd1;
            if (transfer && (issue_count == 8'd0)) begin
                cap_inst  <= inst_out;
                cap_cycle <= cycle_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sic_fetch_feeder.sv
// Randomized bench for sic_fetch_feeder: three configurations against a phase-timeline model.
module tb_sic_fetch_feeder;

    logic        clk = 1'b0;
    logic        reset_x;
    logic [31:0] instruction;
    logic        fetch_ready;

    logic [31:0] d_out  [3];
    logic        d_v    [3];
    logic [7:0]  d_cnt  [3];
    logic [1:0]  d_ph   [3];
    logic        d_done [3];
`ifdef SIC_FEEDER_CAPTURE_EN
    logic [31:0] d_cap_inst [3];
    logic [15:0] d_cap_cyc  [3];
`endif

    int WC [3] = '{4, 4, 0};
    int MI [3] = '{1, 3, 2};
    int DC [3] = '{16, 5, 0};

    int          m_ph   [3];
    int          m_left [3];
    int          m_iss  [3];
    bit          m_v    [3];
    logic [31:0] m_out  [3];
    bit          m_done [3];
    int          m_cyc;
    logic [31:0] m_cap_inst [3];
    int          m_cap_cyc  [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sic_fetch_feeder #(.WARM_CYCLES(4), .MAX_ISSUE(1), .DRAIN_CYCLES(16), .CNT_W(8)) u0 (
        .clk(clk), .reset_x(reset_x), .instruction(instruction), .fetch_ready(fetch_ready),
        .inst_out(d_out[0]), .inst_valid(d_v[0]), .issue_count(d_cnt[0]), .phase(d_ph[0]),
        .run_done(d_done[0])
`ifdef SIC_FEEDER_CAPTURE_EN
        , .cap_inst(d_cap_inst[0]), .cap_cycle(d_cap_cyc[0])
`endif
    );

    sic_fetch_feeder #(.WARM_CYCLES(4), .MAX_ISSUE(3), .DRAIN_CYCLES(5), .CNT_W(8)) u1 (
        .clk(clk), .reset_x(reset_x), .instruction(instruction), .fetch_ready(fetch_ready),
        .inst_out(d_out[1]), .inst_valid(d_v[1]), .issue_count(d_cnt[1]), .phase(d_ph[1]),
        .run_done(d_done[1])
`ifdef SIC_FEEDER_CAPTURE_EN
        , .cap_inst(d_cap_inst[1]), .cap_cycle(d_cap_cyc[1])
`endif
    );

    sic_fetch_feeder #(.WARM_CYCLES(0), .MAX_ISSUE(2), .DRAIN_CYCLES(0), .CNT_W(8)) u2 (
        .clk(clk), .reset_x(reset_x), .instruction(instruction), .fetch_ready(fetch_ready),
        .inst_out(d_out[2]), .inst_valid(d_v[2]), .issue_count(d_cnt[2]), .phase(d_ph[2]),
        .run_done(d_done[2])
`ifdef SIC_FEEDER_CAPTURE_EN
        , .cap_inst(d_cap_inst[2]), .cap_cycle(d_cap_cyc[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_ph[k]       = 0;
            m_left[k]     = WC[k];
            m_iss[k]      = 0;
            m_v[k]        = 1'b0;
            m_out[k]      = '0;
            m_done[k]     = 1'b0;
            m_cap_inst[k] = '0;
            m_cap_cyc[k]  = 0;
        end
        m_cyc = 0;
    endtask

    // Phases: 0 warm-up, 1 issue, 2 drain, 3 done; m_left is cycles remaining in a timed phase.
    task automatic model_step(input logic [31:0] ins, input bit rdy);
        bit xf;
        for (int k = 0; k < 3; k++) begin
            case (m_ph[k])
                0: if (m_left[k] <= 1) m_ph[k] = 1; else m_left[k]--;
                1: begin
                    xf = m_v[k] && rdy;
                    if (xf) begin
                        if (m_iss[k] == 0) begin
                            m_cap_inst[k] = m_out[k];
                            m_cap_cyc[k]  = m_cyc;
                        end
                        m_iss[k]++;
                    end
                    if (xf && m_iss[k] == MI[k]) begin
                        m_v[k] = 1'b0;
                        if (DC[k] == 0) begin
                            m_ph[k] = 3;
                            m_done[k] = 1'b1;
                        end else begin
                            m_ph[k] = 2;
                            m_left[k] = DC[k];
                        end
                    end else if ((!m_v[k] || xf) && m_iss[k] < MI[k]) begin
                        m_out[k] = ins;
                        m_v[k]   = (ins[6:0] != 7'h7F);
                    end
                end
                2: if (m_left[k] <= 1) begin
                    m_ph[k] = 3;
                    m_done[k] = 1'b1;
                end else begin
                    m_left[k]--;
                end
                default: ;
            endcase
        end
        if (m_cyc < 16'hFFFF) m_cyc++;
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d.inst_valid", k), {31'd0, d_v[k]}, {31'd0, m_v[k]});
            chk($sformatf("u%0d.inst_out", k), d_out[k], m_out[k]);
            chk($sformatf("u%0d.issue_count", k), {24'd0, d_cnt[k]}, 32'(m_iss[k]));
            chk($sformatf("u%0d.phase", k), {30'd0, d_ph[k]}, 32'(m_ph[k]));
            chk($sformatf("u%0d.run_done", k), {31'd0, d_done[k]}, {31'd0, m_done[k]});
`ifdef SIC_FEEDER_CAPTURE_EN
            chk($sformatf("u%0d.cap_inst", k), d_cap_inst[k], m_cap_inst[k]);
            chk($sformatf("u%0d.cap_cycle", k), {16'd0, d_cap_cyc[k]}, 32'(m_cap_cyc[k]));
`endif
        end
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [6:0]  ops [9];
        logic [31:0] w;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        w = $urandom();
        if ($urandom_range(0, 3) == 0) w[6:0] = 7'h7F;
        else w[6:0] = ops[$urandom_range(0, 8)];
        return w;
    endfunction

    // Called at a falling edge: drive, let the DUT sample, advance the model, check.
    task automatic cycle(input logic [31:0] ins, input bit rdy);
        instruction = ins;
        fetch_ready = rdy;
        @(posedge clk);
        if (reset_x) model_step(ins, rdy);
        @(negedge clk);
        check_all();
    endtask

    task automatic pulse_reset();
        #2 reset_x = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        check_all();
        reset_x = 1'b1;
    endtask

    initial begin
        logic [31:0] w_add;
        logic [31:0] w_addi;
        logic [31:0] w_stall;
        logic [31:0] ins;
        bit          rdy;
        w_add   = 32'h00208033;
        w_addi  = 32'h00A00093;
        w_stall = 32'h0000007F;

        reset_x     = 1'b0;
        instruction = '0;
        fetch_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset_x = 1'b1;

        for (int c = 0; c < 40; c++) begin
            if (c < 6) ins = w_add;
            else if (c == 6) ins = w_stall;
            else if (c == 7) ins = w_addi;
            else ins = rnd_inst();
            rdy = !(c >= 6 && c <= 10);
            cycle(ins, rdy);
        end
        pulse_reset();

        // Abort u0 part-way through its drain, then run to completion.
        for (int c = 0; c < 15; c++) cycle(w_add, 1'b1);
        pulse_reset();
        for (int c = 0; c < 30; c++) cycle(rnd_inst(), 1'b1);
        pulse_reset();

        for (int s = 0; s < 6; s++) begin
            int len;
            len = $urandom_range(10, 60);
            for (int c = 0; c < len; c++) cycle(rnd_inst(), ($urandom_range(0, 3) != 0));
            pulse_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
